alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle sequencer that computes the low 16 bits of a 16x16 unsigned/two's-complement product by driving the shared ALU with SHL and ADD operations, MSB-first shift-and-add. It sits beside the ALU in the core and competes for it through a request/grant pair. The ALU itself is not instantiated inside; it stays shareable with the main pipeline.

## Interface
- SKIP_ZERO_ADD, default 1: when 1, the ADD step is omitted for multiplier bits equal to 0. When 0, every bit takes an ADD step, giving fixed latency.
- i_clk  input  1  clock; all state updates on rising edge
- i_rstn  input  1  reset; asynchronous, active-low
- i_start  input  1  start request, sampled only in IDLE
- i_opA  input  16  multiplicand, latched at start
- i_opB  input  16  multiplier, latched at start
- o_busy  output  1  high in SHIFT, ADD and DONE
- o_done  output  1  one-cycle pulse, high in DONE
- o_result  output  16  product low 16 bits; registered, held until next DONE
- o_aluReq  output  1  ALU request, high in SHIFT and ADD
- i_aluGrant  input  1  ALU granted this cycle; ignored when o_aluReq=0
- o_aluSrcA  output  16  ALU operand A
- o_aluSrcB  output  16  ALU operand B
- o_aluOpCode  output  3  ALU opcode
- o_aluOpSel  output  1  ALU opcode modifier, always 0
- i_aluResult  input  16  ALU combinational result for the driven operation

## Operation
- **Internal registers**
  - mcand[15:0], mplier[15:0], acc[15:0]
  - cnt[3:0]: bits processed minus one
  - bit: current multiplier bit
- **IDLE**
  - With i_start=1, load: mcand=i_opA, mplier=i_opB, acc=0, cnt=0. Go to SHIFT.
  - Otherwise stay.
- **SHIFT**
  - Drive: o_aluReq=1, opcode 3'b100 (SHL), srcA=acc, srcB=16'h0001.
  - On grant:
    - acc<=i_aluResult; bit<=mplier[15]; mplier<=mplier<<1.
    - If mplier[15]=1 or SKIP_ZERO_ADD=0, go to ADD.
    - Otherwise, if cnt=15 go to DONE; else cnt++ and stay in SHIFT.
- **ADD**
  - Drive: o_aluReq=1, opcode 3'b000 (ADD), srcA=acc, srcB=mcand.
  - On grant:
    - If bit=1, acc<=i_aluResult; otherwise acc is unchanged (SKIP_ZERO_ADD=0 case).
    - If cnt=15 go to DONE; else cnt++ and go to SHIFT.
- **DONE**
  - o_done=1, o_result<=acc (registered on entry, so o_result is valid while o_done=1).
  - Go to IDLE.
- **Arithmetic**
  - Modulo 2^16; carry and ccodes are ignored.
  - Result is correct for both unsigned and two's-complement operands (low half).
- **No grant**
  - State, registers and all ALU-side outputs hold exactly. Operands stay stable while requesting.
- **Idle bus**
  - When o_aluReq=0: o_aluSrcA=0, o_aluSrcB=0, o_aluOpCode=000, o_aluOpSel=0.
- **Start rules**
  - i_start while busy is ignored and not queued.
  - i_start in DONE is ignored; it is accepted in the following IDLE cycle.
- **Reset**
  - Values: state=IDLE, all registers 0, o_result=0, o_done=0, o_busy=0, o_aluReq=0, ALU outputs 0.
  - Reset mid-operation aborts with no done pulse.

## Timing
- i_start sampled at edge E0; SHIFT is active in cycle 1.
- With grant always high:
  - N ALU cycles, where N = 16 + popcount(i_opB) for SKIP_ZERO_ADD=1, or 32 for SKIP_ZERO_ADD=0.
  - o_done high during cycle N+1 after E0.
  - Earliest next start is sampled at the edge ending the first IDLE cycle.
- Each grant-low cycle while requesting adds exactly one cycle of latency.
- The ALU path is combinational within one cycle: ALU outputs come from registers, and i_aluResult is captured at the same edge.
- o_busy and o_done are registered state decodes, with no combinational path from i_start.

## Structure
- **Shared package alu_pkg**
  - ALU opcode constants: ADD=000, SUB=001, LBI=010, XOR=011, SHL=100, SHR=101, ORR=110, AND=111.
  - State typedef: IDLE, SHIFT, ADD, DONE.
- **Sub-modules:** none. It is a single FSM plus datapath registers, and ALU muxing stays external.

## Test plan
- 3 x 5, grant tied high, SKIP=1: done in cycle 19 after start (N=18), o_result=0x000F. Opcode sequence: SHL×13, then SHL,ADD,SHL,SHL,ADD.
- 0xFFFF x 0xFFFF, SKIP=1: N=32, o_result=0x0001. SKIP=0 with 0x1234 x 0: N=32, o_result=0x0000, acc never modified by ADD.
- 0x0100 x 0x0100: o_result=0x0000 (overflow wraps). 0xFFFE x 0x0003 (−2×3): o_result=0xFFFA.
- Random grant with 50% low: o_result matches the full-grant run. ALU outputs are stable across every grant-low cycle. Latency = N + number of denied request cycles.
- i_start pulsed in cycles 5 and in DONE during a 7 x 9 run: single done pulse, o_result=0x003F. Next start accepted only from IDLE.
- i_rstn low mid-SHIFT: immediately o_busy=0, o_aluReq=0, o_result=0, no o_done. A fresh 2 x 2 afterwards gives 0x0004.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the multiply-sequencer state type.
// Imported by the sequencer and by anything else that drives the shared ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_LBI = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SHL = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;
    localparam logic [2:0] ALU_ORR = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_ADD   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_mul_sequencer.sv
// MSB-first shift-and-add multiplier that borrows the shared ALU through a req/grant
// handshake; produces the low 16 bits of opA*opB.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter bit SKIP_ZERO_ADD = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [15:0] i_opA,
    input  logic [15:0] i_opB,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_result,
    output logic        o_aluReq,
    input  logic        i_aluGrant,
    output logic [15:0] o_aluSrcA,
    output logic [15:0] o_aluSrcB,
    output logic [2:0]  o_aluOpCode,
    output logic        o_aluOpSel,
    input  logic [15:0] i_aluResult
);

    state_t      state, stateNext;
    logic [15:0] mcand, mplier, acc, accNext;
    logic [3:0]  cnt;
    logic        curBit;
    logic        lastBit;

    assign lastBit = (cnt == 4'd15);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext = state;
        accNext   = acc;
        case (state)
            ST_IDLE: begin
                if (i_start) stateNext = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (i_aluGrant) begin
                    accNext = i_aluResult;
                    if (mplier[15] || !SKIP_ZERO_ADD) stateNext = ST_ADD;
                    else if (lastBit)                 stateNext = ST_DONE;
                end
            end
            ST_ADD: begin
                if (i_aluGrant) begin
                    // A zero multiplier bit still occupies the ADD slot when skipping is off.
                    if (curBit) accNext = i_aluResult;
                    stateNext = lastBit ? ST_DONE : ST_SHIFT;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ST_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            curBit   <= 1'b0;
            o_result <= '0;
        end else begin
            state <= stateNext;
            acc   <= accNext;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        mcand  <= i_opA;
                        mplier <= i_opB;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (i_aluGrant) begin
                        curBit <= mplier[15];
                        mplier <= mplier << 1;
                        if (stateNext == ST_SHIFT) cnt <= cnt + 4'd1;
                    end
                end
                ST_ADD: begin
                    if (i_aluGrant && stateNext == ST_SHIFT) cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
            // Result is captured on the way into DONE so it is valid alongside o_done.
            if (stateNext == ST_DONE && state != ST_DONE) o_result <= accNext;
        end
    end

    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);
    assign o_aluReq   = (state == ST_SHIFT) || (state == ST_ADD);
    assign o_aluOpSel = 1'b0;

    always_comb begin
        o_aluSrcA   = '0;
        o_aluSrcB   = '0;
        o_aluOpCode = ALU_ADD;
        case (state)
            ST_SHIFT: begin
                o_aluSrcA   = acc;
                o_aluSrcB   = 16'h0001;
                o_aluOpCode = ALU_SHL;
            end
            ST_ADD: begin
                o_aluSrcA   = acc;
                o_aluSrcB   = mcand;
                o_aluOpCode = ALU_ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: two instances (skip on / skip off) share a behavioural ALU
// and are checked against an arithmetic product and bit-derived opcode sequence model.
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        start    [2];
    logic [15:0] opA      [2];
    logic [15:0] opB      [2];
    logic        grant    [2];
    logic        busy     [2];
    logic        done     [2];
    logic        aluReq   [2];
    logic        aluOpSel [2];
    logic [15:0] result   [2];
    logic [15:0] srcA     [2];
    logic [15:0] srcB     [2];
    logic [15:0] aluRes   [2];
    logic [2:0]  opCode   [2];

    int testsRun    = 0;
    int testsFailed = 0;

    function automatic logic [15:0] aluModel(logic [2:0] op, logic [15:0] a, logic [15:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_LBI: return b;
            ALU_XOR: return a ^ b;
            ALU_SHL: return a << b[3:0];
            ALU_SHR: return a >> b[3:0];
            ALU_ORR: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign aluRes[0] = aluModel(opCode[0], srcA[0], srcB[0]);
    assign aluRes[1] = aluModel(opCode[1], srcA[1], srcB[1]);

    alu_mul_sequencer #(.SKIP_ZERO_ADD(1'b0)) dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start[0]), .i_opA(opA[0]), .i_opB(opB[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_result(result[0]), .o_aluReq(aluReq[0]),
        .i_aluGrant(grant[0]), .o_aluSrcA(srcA[0]), .o_aluSrcB(srcB[0]),
        .o_aluOpCode(opCode[0]), .o_aluOpSel(aluOpSel[0]), .i_aluResult(aluRes[0])
    );

    alu_mul_sequencer #(.SKIP_ZERO_ADD(1'b1)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start[1]), .i_opA(opA[1]), .i_opB(opB[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_result(result[1]), .o_aluReq(aluReq[1]),
        .i_aluGrant(grant[1]), .o_aluSrcA(srcA[1]), .o_aluSrcB(srcB[1]),
        .o_aluOpCode(opCode[1]), .o_aluOpSel(aluOpSel[1]), .i_aluResult(aluRes[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One multiply on instance sel (sel=1 skips zero ADDs). denyPct is the grant-low rate.
    task automatic runMul(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input int denyPct, input bit pokeStart, input string tag);
        logic [2:0]  expOps[$];
        logic [2:0]  gotOps[$];
        logic [15:0] expRes;
        logic [15:0] gotRes;
        logic [36:0] bus, prevBus;
        bit          prevHeld = 1'b0;
        bit          seen     = 1'b0;
        bit          g;
        int          denied = 0, cycles = 0, opErr = 0, stabErr = 0;

        for (int i = 15; i >= 0; i--) begin
            expOps.push_back(ALU_SHL);
            if (b[i] || sel == 0) expOps.push_back(ALU_ADD);
        end
        expRes = a * b;
        gotRes = '0;
        prevBus = '0;

        @(negedge clk);
        opA[sel] = a; opB[sel] = b; start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        while (cycles < 300) begin
            cycles++;
            bus = {aluReq[sel], aluOpSel[sel], opCode[sel], srcA[sel], srcB[sel]};
            if (prevHeld && bus !== prevBus) stabErr++;
            if (done[sel]) begin
                seen = 1'b1;
                break;
            end
            if (pokeStart && cycles == 5) begin
                start[sel] = 1'b1; opA[sel] = ~a; opB[sel] = ~b;
            end else if (pokeStart && cycles == 6) begin
                start[sel] = 1'b0; opA[sel] = a; opB[sel] = b;
            end
            g = ($urandom_range(99) >= denyPct);
            grant[sel] = g;
            if (aluReq[sel]) begin
                if (aluOpSel[sel] !== 1'b0) opErr++;
                if (opCode[sel] == ALU_SHL && srcB[sel] !== 16'h0001) opErr++;
                if (opCode[sel] == ALU_ADD && srcB[sel] !== a) opErr++;
                if (g) gotOps.push_back(opCode[sel]);
                else   denied++;
            end
            prevHeld = aluReq[sel] && !g;
            prevBus  = bus;
            @(negedge clk);
        end

        gotRes = result[sel];
        check({tag, "/done"}, 64'(seen), 64'd1);
        check({tag, "/latency"}, 64'(cycles), 64'(expOps.size() + denied + 1));
        check({tag, "/result"}, 64'(gotRes), 64'(expRes));
        check({tag, "/busyInDone"}, 64'(busy[sel]), 64'd1);
        check({tag, "/idleBus"}, 64'(bus), 64'd0);
        for (int i = 0; i < expOps.size(); i++)
            if (i >= gotOps.size() || gotOps[i] !== expOps[i]) opErr++;
        check({tag, "/opCount"}, 64'(gotOps.size()), 64'(expOps.size()));
        check({tag, "/opSeq"}, 64'(opErr), 64'd0);
        if (denyPct > 0) check({tag, "/stable"}, 64'(stabErr), 64'd0);

        if (pokeStart) start[sel] = 1'b1;
        grant[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        check({tag, "/doneOnce"}, 64'(done[sel]), 64'd0);
        check({tag, "/idleAfter"}, 64'(busy[sel]), 64'd0);
        @(negedge clk);
        check({tag, "/noQueuedStart"}, 64'(busy[sel]), 64'd0);
    endtask

    initial begin
        int pulses;
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; opA[k] = '0; opB[k] = '0; grant[k] = 1'b1;
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset%0d/busy", k), 64'(busy[k]), 64'd0);
            check($sformatf("reset%0d/done", k), 64'(done[k]), 64'd0);
            check($sformatf("reset%0d/result", k), 64'(result[k]), 64'd0);
            check($sformatf("reset%0d/bus", k),
                  64'({aluReq[k], aluOpSel[k], opCode[k], srcA[k], srcB[k]}), 64'd0);
        end
        @(negedge clk);
        rstn = 1'b1;

        runMul(1, 16'h0003, 16'h0005, 0, 1'b0, "3x5");
        runMul(1, 16'hFFFF, 16'hFFFF, 0, 1'b0, "ffffxffff");
        runMul(0, 16'h1234, 16'h0000, 0, 1'b0, "noSkip1234x0");
        runMul(1, 16'h0100, 16'h0100, 0, 1'b0, "wrap");
        runMul(1, 16'hFFFE, 16'h0003, 0, 1'b0, "neg2x3");
        runMul(1, 16'h0007, 16'h0009, 0, 1'b1, "startRules7x9");
        runMul(0, 16'h00FF, 16'h0101, 50, 1'b0, "noSkipGrant");

        for (int r = 0; r < 6; r++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            runMul(1, ra, rb, 50, 1'b0, $sformatf("rand%0d/skip", r));
            runMul(0, ra, rb, 50, 1'b0, $sformatf("rand%0d/noSkip", r));
        end

        // Abort a run in SHIFT with an asynchronous reset.
        @(negedge clk);
        opA[1] = 16'h1234; opB[1] = 16'h5678; start[1] = 1'b1; grant[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort/busy", 64'(busy[1]), 64'd0);
        check("abort/aluReq", 64'(aluReq[1]), 64'd0);
        check("abort/result", 64'(result[1]), 64'd0);
        check("abort/done", 64'(done[1]), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done[1]) pulses++;
        end
        check("abort/noDonePulse", 64'(pulses), 64'd0);
        runMul(1, 16'h0002, 16'h0002, 0, 1'b0, "after2x2");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
